match_counter: RTL and testbench

MATCH_COUNTER -- requirements
Module: match_counter

---
 rtl/match_counter_if.sv | 37 +++
 rtl/match_counter.sv | 166 ++++++++++++++++
 tb/tb_match_counter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/match_counter_if.sv
// -----------------------------------------------------------------------------
// match_counter_if
//   Bundles the match-statistics signals of match_counter.
//   Signal directions are named from the match_counter's point of view.
//
//   clear_i    : synchronous active-high clear of all statistics
//   z_i        : match flag from the sequence-detector stage (same clock domain)
//   pulse_o    : one-cycle strobe following each z rising edge
//   active_o   : high while the block is in state HIGH
//   count_o    : saturating count of z rising edges
//   run_o      : length of the current or most recent z-high run (saturating)
//   max_run_o  : longest completed z-high run since reset or clear
//
//   Modports: master (drives clear_i/z_i, observes the results)
//             slave  (match_counter itself)
// -----------------------------------------------------------------------------
interface match_counter_if #(
    parameter int CW = 8
);
    logic          clear_i;
    logic          z_i;
    logic          pulse_o;
    logic          active_o;
    logic [CW-1:0] count_o;
    logic [CW-1:0] run_o;
    logic [CW-1:0] max_run_o;

    modport master (
        output clear_i, z_i,
        input  pulse_o, active_o, count_o, run_o, max_run_o
    );

    modport slave (
        input  clear_i, z_i,
        output pulse_o, active_o, count_o, run_o, max_run_o
    );
endinterface : match_counter_if

// File: rtl/match_counter.sv
// -----------------------------------------------------------------------------
// match_counter
//   Collects statistics on the match flag z from a sequence detector:
//   number of rising edges, the length of the current/most recent z-high run
//   and the longest completed run. All counters are unsigned CW-bit values
//   that saturate at 2^CW-1 and then hold.
//
//   Ports:
//     clk    : system clock, all updates on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : match_counter_if.slave (clear_i, z_i in; pulse_o, active_o,
//              count_o, run_o, max_run_o out)
//     hex0_o : (MATCH_COUNTER_SEG7_EN only) active-low 7-seg digit of count[3:0]
//     hex1_o : (MATCH_COUNTER_SEG7_EN only) active-low 7-seg digit of count[7:4]
//
//   Configuration:
//     MATCH_COUNTER_SEG7_EN - when defined, adds the registered hex display
//                             outputs; requires CW >= 8. When undefined the
//                             hex ports and their logic are absent.
// -----------------------------------------------------------------------------
module match_counter #(
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    match_counter_if.slave        bus
`ifdef MATCH_COUNTER_SEG7_EN
    ,
    output logic [6:0]            hex0_o,
    output logic [6:0]            hex1_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_e;

    localparam logic [CW-1:0] SAT_VAL = '1;

    state_e        state_q;
    logic          z_d_q;
    logic          pulse_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] run_q;
    logic [CW-1:0] max_run_q;

    logic          rise_d;
    logic [CW-1:0] count_d;
    logic [CW-1:0] run_d;
    logic [CW-1:0] max_run_d;

    // Saturating increments and the edge detect. A rising edge is z high now
    // while it was low at the previous posedge; after reset z_d_q is 0, so z
    // already high at the first edge counts.
    always_comb begin
        // NOTE: every combinational output gets a value on every path (here
        // unconditionally) so no latch is inferred.
        rise_d    = bus.z_i & ~z_d_q;
        count_d   = (count_q == SAT_VAL) ? count_q : count_q + CW'(1);
        run_d     = (run_q   == SAT_VAL) ? run_q   : run_q   + CW'(1);
        max_run_d = (run_q > max_run_q)  ? run_q   : max_run_q;
    end

    // Single-process FSM with all statistics registered alongside the state.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            z_d_q     <= 1'b0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
            run_q     <= '0;
            max_run_q <= '0;
        end else begin
            // z history keeps tracking through a clear, so a z held high
            // across the clear is not seen as a fresh edge afterwards.
            z_d_q <= bus.z_i;

            if (bus.clear_i) begin
                // Clear wins over everything; an open run is discarded
                // without being committed to max_run.
                state_q   <= IDLE;
                pulse_q   <= 1'b0;
                count_q   <= '0;
                run_q     <= '0;
                max_run_q <= '0;
            end else begin
                pulse_q <= rise_d;
                if (rise_d) begin
                    count_q <= count_d;
                end

                case (state_q)
                    IDLE: begin
                        if (bus.z_i) begin
                            state_q <= HIGH;
                            run_q   <= CW'(1);
                        end
                    end
                    HIGH: begin
                        if (bus.z_i) begin
                            run_q <= run_d;
                        end else begin
                            // Run completed: run keeps its final length.
                            state_q   <= IDLE;
                            max_run_q <= max_run_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.pulse_o   = pulse_q;
    assign bus.active_o  = (state_q == HIGH);
    assign bus.count_o   = count_q;
    assign bus.run_o     = run_q;
    assign bus.max_run_o = max_run_q;

`ifdef MATCH_COUNTER_SEG7_EN
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [6:0] hex0_q;
    logic [6:0] hex1_q;

    // Display trails count by one cycle; reset shows a blank (all segments off).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex0_q <= 7'h7F;
            hex1_q <= 7'h7F;
        end else begin
            hex0_q <= seg7(count_q[3:0]);
            hex1_q <= seg7(count_q[7:4]);
        end
    end

    assign hex0_o = hex0_q;
    assign hex1_o = hex1_q;
`endif

endmodule : match_counter

// File: tb/tb_match_counter.sv
// -----------------------------------------------------------------------------
// tb_match_counter
//   Self-checking bench for match_counter. A cycle-level reference model of
//   the statistics (edge count, run lengths, longest completed run) is kept
//   in plain integers and compared with the DUT after every clock; directed
//   sequences cover reset, clear, toggling and saturation, followed by a
//   randomized phase.
// -----------------------------------------------------------------------------
module tb_match_counter;

    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    match_counter_if #(.CW(CW)) bus ();

`ifdef MATCH_COUNTER_SEG7_EN
    logic [6:0] hex0;
    logic [6:0] hex1;
`endif

    match_counter #(.CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus)
`ifdef MATCH_COUNTER_SEG7_EN
        ,
        .hex0_o (hex0),
        .hex1_o (hex1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;

    // Reference model state.
    int m_zprev, m_high, m_count, m_run, m_max, m_pulse;
`ifdef MATCH_COUNTER_SEG7_EN
    int m_hex0, m_hex1;

    function automatic int seg_ref(input int v);
        int tbl[16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                        'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
        return tbl[v & 15];
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_zprev = 0; m_high = 0; m_count = 0; m_run = 0; m_max = 0; m_pulse = 0;
`ifdef MATCH_COUNTER_SEG7_EN
        m_hex0 = 'h7F; m_hex1 = 'h7F;
`endif
    endtask

    // One posedge of behaviour, from the block's rules.
    task automatic model_step(input int z, input int clr);
        int rise;
        rise = (z == 1 && m_zprev == 0) ? 1 : 0;
`ifdef MATCH_COUNTER_SEG7_EN
        m_hex0 = seg_ref(m_count % 16);
        m_hex1 = seg_ref((m_count / 16) % 16);
`endif
        if (clr != 0) begin
            m_count = 0; m_run = 0; m_max = 0; m_pulse = 0; m_high = 0;
        end else begin
            m_pulse = rise;
            if (rise != 0 && m_count < MAXV) m_count++;
            if (z != 0) begin
                if (m_high != 0) m_run = (m_run < MAXV) ? m_run + 1 : MAXV;
                else             m_run = 1;
                m_high = 1;
            end else begin
                if (m_high != 0 && m_run > m_max) m_max = m_run;
                m_high = 0;
            end
        end
        m_zprev = z;
    endtask

    task automatic compare_all();
        check("pulse",   32'(bus.pulse_o),   32'(m_pulse));
        check("active",  32'(bus.active_o),  32'(m_high));
        check("count",   32'(bus.count_o),   32'(m_count));
        check("run",     32'(bus.run_o),     32'(m_run));
        check("max_run", 32'(bus.max_run_o), 32'(m_max));
`ifdef MATCH_COUNTER_SEG7_EN
        check("hex0",    32'(hex0),          32'(m_hex0));
        check("hex1",    32'(hex1),          32'(m_hex1));
`endif
    endtask

    // Inputs change 1 time unit after a posedge; outputs are sampled there too.
    task automatic tick(input int z, input int clr);
        bus.z_i     = (z != 0);
        bus.clear_i = (clr != 0);
        @(posedge clk);
        model_step(z, clr);
        #1;
        if (bus.pulse_o) pulses_seen++;
        compare_all();
    endtask

    initial begin
        int base;
        rst_n       = 1'b0;
        bus.z_i     = 1'b0;
        bus.clear_i = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // z high at the very first posedge after reset is a rising edge.
        tick(1, 0);
        check("first_edge_count", 32'(bus.count_o), 32'd1);
        tick(0, 0);

        // 4 high, 2 low, 6 high, low.
        tick(0, 1);
        tick(0, 0);
        base = pulses_seen;
        repeat (4) tick(1, 0);
        repeat (2) tick(0, 0);
        repeat (6) tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        check("runs_count",   32'(bus.count_o),       32'd2);
        check("runs_run",     32'(bus.run_o),         32'd6);
        check("runs_max",     32'(bus.max_run_o),     32'd6);
        check("runs_pulses",  32'(pulses_seen - base), 32'd2);

        // Alternating 1/0 for 10 cycles.
        tick(0, 1);
        base = pulses_seen;
        for (int i = 0; i < 10; i++) tick((i % 2 == 0) ? 1 : 0, 0);
        tick(0, 0);
        check("alt_count",  32'(bus.count_o),        32'd5);
        check("alt_max",    32'(bus.max_run_o),      32'd1);
        check("alt_pulses", 32'(pulses_seen - base), 32'd5);

        // Clear while in HIGH with count 7; held-high z is not a new edge.
        tick(0, 1);
        repeat (6) begin tick(1, 0); tick(0, 0); end
        tick(1, 0);
        tick(1, 0);
        check("pre_clear_count",  32'(bus.count_o),  32'd7);
        check("pre_clear_active", 32'(bus.active_o), 32'd1);
        tick(1, 1);
        check("clear_count",  32'(bus.count_o),  32'd0);
        check("clear_active", 32'(bus.active_o), 32'd0);
        repeat (3) tick(1, 0);
        check("clear_no_edge", 32'(bus.count_o), 32'd0);
        tick(0, 0);
        tick(1, 0);
        check("clear_new_edge", 32'(bus.count_o), 32'd1);

        // Asynchronous reset mid-run with count 5, run 3.
        tick(0, 1);
        repeat (4) begin tick(1, 0); tick(0, 0); end
        repeat (3) tick(1, 0);
        check("pre_rst_count", 32'(bus.count_o), 32'd5);
        check("pre_rst_run",   32'(bus.run_o),   32'd3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        bus.z_i = 1'b0;
        rst_n   = 1'b1;

        // Saturation of count and run.
        tick(0, 1);
        repeat (300) begin tick(1, 0); tick(0, 0); end
        check("sat_count", 32'(bus.count_o), 32'(MAXV));
        tick(0, 1);
        repeat (300) tick(1, 0);
        check("sat_run", 32'(bus.run_o), 32'(MAXV));
        tick(0, 0);
        check("sat_max", 32'(bus.max_run_o), 32'(MAXV));

`ifdef MATCH_COUNTER_SEG7_EN
        // count = 0x3A shows "3A" one cycle later.
        tick(0, 1);
        repeat (58) begin tick(1, 0); tick(0, 0); end
        tick(0, 0);
        check("hex_count", 32'(bus.count_o), 32'h3A);
        check("hex1_3",    32'(hex1),        32'h30);
        check("hex0_A",    32'(hex0),        32'h08);
`endif

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 3000; i++) begin
            int z, clr;
            z   = ($urandom_range(0, 99) < 55) ? m_zprev : 1 - m_zprev;
            clr = ($urandom_range(0, 63) == 0) ? 1 : 0;
            tick(z, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_match_counter
